// File: rtl/elastic_buffer_if.sv
// Write/read handshake and status bundle of the single-clock elastic buffer.
// The master side is the producer/consumer; the slave side is the buffer itself.
interface elastic_buffer_if #(
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                 clr_i;
    logic                 wr_i;
    logic [DATA_SIZE-1:0] d_i;
    logic                 rd_i;
    logic                 full_o;
    logic                 almost_full_o;
    logic [DATA_SIZE-1:0] q_o;
    logic                 empty_o;
    logic                 almost_empty_o;
    logic [LVL_W-1:0]     level_o;
    logic                 overflow_o;
    logic                 underflow_o;

    modport master (
        output clr_i, wr_i, d_i, rd_i,
        input  full_o, almost_full_o, q_o, empty_o, almost_empty_o,
               level_o, overflow_o, underflow_o
    );

    modport slave (
        input  clr_i, wr_i, d_i, rd_i,
        output full_o, almost_full_o, q_o, empty_o, almost_empty_o,
               level_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/elastic_buffer.sv
// Single-clock first-word-fall-through elastic buffer with fill level,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module elastic_buffer #(
    parameter int DATA_SIZE              = 32,
    parameter int DEPTH                  = 4,
    parameter int ALMOST_FULL_THRESHOLD  = DEPTH - 1,
    parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    elastic_buffer_if.slave        bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AF_L    = LVL_W'(ALMOST_FULL_THRESHOLD);
    localparam logic [LVL_W-1:0] AE_L    = LVL_W'(ALMOST_EMPTY_THRESHOLD);
    localparam logic [LVL_W-1:0] ZERO_L  = {LVL_W{1'b0}};

    logic [DATA_SIZE-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]     wrptr_r;
    logic [PTR_W-1:0]     rdptr_r;
    logic [LVL_W-1:0]     level_r;
    logic                 full_r;
    logic                 empty_r;
    logic                 almost_full_r;
    logic                 almost_empty_r;
    logic                 overflow_r;
    logic                 underflow_r;

    logic                 flush_s;
    logic                 wa_s;
    logic                 ra_s;
    logic [PTR_W-1:0]     wrptr_nxt_s;
    logic [PTR_W-1:0]     rdptr_nxt_s;
    logic [LVL_W-1:0]     level_nxt_s;
    logic                 overflow_nxt_s;
    logic                 underflow_nxt_s;

    // Accept decisions look only at registered status, keeping strobes off every output path.
    always_comb begin
        flush_s = rst_i | bus.clr_i;
        wa_s    = 1'b0;
        ra_s    = 1'b0;
        if (flush_s) begin
            wa_s = 1'b0;
            ra_s = 1'b0;
        end else begin
            wa_s = bus.wr_i & (~full_r | bus.rd_i);
            ra_s = bus.rd_i & ~empty_r;
        end
    end

    // Next pointers, level and sticky error flags.
    always_comb begin
        wrptr_nxt_s     = wrptr_r;
        rdptr_nxt_s     = rdptr_r;
        level_nxt_s     = level_r;
        overflow_nxt_s  = overflow_r;
        underflow_nxt_s = underflow_r;
        if (flush_s) begin
            wrptr_nxt_s     = {PTR_W{1'b0}};
            rdptr_nxt_s     = {PTR_W{1'b0}};
            level_nxt_s     = ZERO_L;
            overflow_nxt_s  = 1'b0;
            underflow_nxt_s = 1'b0;
        end else begin
            if (wa_s) begin
                wrptr_nxt_s = wrptr_r + PTR_W'(1);
            end else begin
                wrptr_nxt_s = wrptr_r;
            end
            if (ra_s) begin
                rdptr_nxt_s = rdptr_r + PTR_W'(1);
            end else begin
                rdptr_nxt_s = rdptr_r;
            end
            case ({wa_s, ra_s})
                2'b10:   level_nxt_s = level_r + LVL_W'(1);
                2'b01:   level_nxt_s = level_r - LVL_W'(1);
                default: level_nxt_s = level_r;
            endcase
            // A read on an empty buffer is flagged even when a write fills it in the same cycle.
            overflow_nxt_s  = overflow_r | (bus.wr_i & full_r & ~bus.rd_i);
            underflow_nxt_s = underflow_r | (bus.rd_i & empty_r);
        end
    end

    // State and registered status flags, derived from the next level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrptr_r        <= {PTR_W{1'b0}};
            rdptr_r        <= {PTR_W{1'b0}};
            level_r        <= ZERO_L;
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            almost_full_r  <= (AF_L == ZERO_L);
            almost_empty_r <= 1'b1;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
        end else begin
            wrptr_r        <= wrptr_nxt_s;
            rdptr_r        <= rdptr_nxt_s;
            level_r        <= level_nxt_s;
            full_r         <= (level_nxt_s == DEPTH_L);
            empty_r        <= (level_nxt_s == ZERO_L);
            almost_full_r  <= (level_nxt_s >= AF_L);
            almost_empty_r <= (level_nxt_s <= AE_L);
            overflow_r     <= overflow_nxt_s;
            underflow_r    <= underflow_nxt_s;
        end
    end

    // Storage array; contents survive reset and flush.
    always_ff @(posedge clk_i) begin
        if (wa_s) begin
            mem_r[wrptr_r] <= bus.d_i;
        end
    end

    assign bus.q_o            = mem_r[rdptr_r];
    assign bus.full_o         = full_r;
    assign bus.almost_full_o  = almost_full_r;
    assign bus.empty_o        = empty_r;
    assign bus.almost_empty_o = almost_empty_r;
    assign bus.level_o        = level_r;
    assign bus.overflow_o     = overflow_r;
    assign bus.underflow_o    = underflow_r;
endmodule

// File: tb/tb_elastic_buffer.sv
// Bench for elastic_buffer: fixed vector table, hand-written corner sequences,
// then random traffic against a queue-based reference model.
module tb_elastic_buffer;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AF    = DEPTH - 1;
    localparam int AE    = 1;

    logic clk;
    logic rst;

    elastic_buffer_if #(.DATA_SIZE(DW), .DEPTH(DEPTH)) bus ();

    elastic_buffer #(
        .DATA_SIZE(DW), .DEPTH(DEPTH),
        .ALMOST_FULL_THRESHOLD(AF), .ALMOST_EMPTY_THRESHOLD(AE)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit r, c, w, rd;
        logic [DW-1:0] d;
        int lvl;
        bit emp, full, af, ae, ovf, udf, qchk;
        logic [DW-1:0] q;
    } vec_t;

    vec_t          tbl[$];
    logic [DW-1:0] model_q[$];
    bit            m_ovf;
    bit            m_udf;
    int            n_vec = 0;
    int            n_bad = 0;

    function automatic vec_t mk(input bit r, c, w, rd, input logic [DW-1:0] d,
                                input int lvl, input bit emp, full, af, ae, ovf, udf, qchk,
                                input logic [DW-1:0] q);
        vec_t v;
        v.r = r; v.c = c; v.w = w; v.rd = rd; v.d = d; v.lvl = lvl;
        v.emp = emp; v.full = full; v.af = af; v.ae = ae;
        v.ovf = ovf; v.udf = udf; v.qchk = qchk; v.q = q;
        return v;
    endfunction

    task automatic model_step(input bit r, c, w, rd, input logic [DW-1:0] d);
        bit was_empty;
        bit was_full;
        was_empty = (model_q.size() == 0);
        was_full  = (model_q.size() == DEPTH);
        if (r || c) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (rd && was_empty) m_udf = 1'b1;
            if (w && was_full && !rd) m_ovf = 1'b1;
            if (rd && !was_empty) void'(model_q.pop_front());
            if (w && (!was_full || rd)) model_q.push_back(d);
        end
    endtask

    task automatic apply(input bit r, c, w, rd, input logic [DW-1:0] d);
        rst = r; bus.clr_i = c; bus.wr_i = w; bus.rd_i = rd; bus.d_i = d;
        @(posedge clk);
        model_step(r, c, w, rd, d);
        #1;
        rst = 1'b0; bus.clr_i = 1'b0; bus.wr_i = 1'b0; bus.rd_i = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int lvl,
                                 input bit emp, full, af, ae, ovf, udf, qchk,
                                 input logic [DW-1:0] q);
        chk({tag, ".level"},        DW'(bus.level_o),        DW'(lvl));
        chk({tag, ".empty"},        DW'(bus.empty_o),        DW'(emp));
        chk({tag, ".full"},         DW'(bus.full_o),         DW'(full));
        chk({tag, ".almost_full"},  DW'(bus.almost_full_o),  DW'(af));
        chk({tag, ".almost_empty"}, DW'(bus.almost_empty_o), DW'(ae));
        chk({tag, ".overflow"},     DW'(bus.overflow_o),     DW'(ovf));
        chk({tag, ".underflow"},    DW'(bus.underflow_o),    DW'(udf));
        if (qchk) chk({tag, ".q"}, bus.q_o, q);
    endtask

    task automatic check_model(input string tag);
        int lvl;
        logic [DW-1:0] head;
        lvl  = model_q.size();
        head = '0;
        if (lvl != 0) head = model_q[0];
        check_outputs(tag, lvl, lvl == 0, lvl == DEPTH, lvl >= AF, lvl <= AE,
                      m_ovf, m_udf, lvl != 0, head);
    endtask

    task automatic flush_seq(input bit use_rst, input string tag);
        apply(0, 1, 0, 0, 32'h0);
        for (int i = 0; i < DEPTH; i++) apply(0, 0, 1, 0, 32'hE0 + DW'(i));
        apply(0, 0, 1, 0, 32'hFF);
        apply(0, 0, 0, 1, 32'h0);
        check_outputs({tag, ".pre"}, 3, 0, 0, 1, 0, 1, 0, 1, 32'hE1);
        apply(use_rst, !use_rst, 1, 0, 32'hEE);
        check_outputs({tag, ".flushed"}, 0, 1, 0, 0, 1, 0, 0, 0, 32'h0);
        apply(0, 0, 1, 0, 32'h5A);
        check_outputs({tag, ".after"}, 1, 0, 0, 0, 1, 0, 0, 1, 32'h5A);
        apply(0, 0, 0, 1, 32'h0);
        check_outputs({tag, ".drain"}, 0, 1, 0, 0, 1, 0, 0, 0, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wbias;
        bit r, c, w, rd;
        rst = 1'b1; bus.clr_i = 1'b0; bus.wr_i = 1'b0; bus.rd_i = 1'b0; bus.d_i = '0;
        m_ovf = 1'b0; m_udf = 1'b0;

        //                 r c w rd d        lvl e f af ae ov ud qc q
        tbl.push_back(mk(1,0,0,0, 32'h00,   0, 1,0,0,1, 0,0, 0, 32'h00));
        tbl.push_back(mk(0,0,1,0, 32'hA0,   1, 0,0,0,1, 0,0, 1, 32'hA0));
        tbl.push_back(mk(0,0,1,0, 32'hA1,   2, 0,0,0,0, 0,0, 1, 32'hA0));
        tbl.push_back(mk(0,0,1,0, 32'hA2,   3, 0,0,1,0, 0,0, 1, 32'hA0));
        tbl.push_back(mk(0,0,1,0, 32'hA3,   4, 0,1,1,0, 0,0, 1, 32'hA0));
        tbl.push_back(mk(0,0,1,0, 32'hFF,   4, 0,1,1,0, 1,0, 1, 32'hA0));
        tbl.push_back(mk(0,0,0,1, 32'h00,   3, 0,0,1,0, 1,0, 1, 32'hA1));
        tbl.push_back(mk(0,0,0,1, 32'h00,   2, 0,0,0,0, 1,0, 1, 32'hA2));
        tbl.push_back(mk(0,0,0,1, 32'h00,   1, 0,0,0,1, 1,0, 1, 32'hA3));
        tbl.push_back(mk(0,0,0,1, 32'h00,   0, 1,0,0,1, 1,0, 0, 32'h00));
        tbl.push_back(mk(0,1,0,0, 32'h00,   0, 1,0,0,1, 0,0, 0, 32'h00));
        tbl.push_back(mk(0,0,1,0, 32'h10,   1, 0,0,0,1, 0,0, 1, 32'h10));
        tbl.push_back(mk(0,0,1,0, 32'h11,   2, 0,0,0,0, 0,0, 1, 32'h10));
        tbl.push_back(mk(0,0,1,0, 32'h12,   3, 0,0,1,0, 0,0, 1, 32'h10));
        tbl.push_back(mk(0,0,1,0, 32'h13,   4, 0,1,1,0, 0,0, 1, 32'h10));
        tbl.push_back(mk(0,0,1,1, 32'hB0,   4, 0,1,1,0, 0,0, 1, 32'h11));
        tbl.push_back(mk(0,0,0,1, 32'h00,   3, 0,0,1,0, 0,0, 1, 32'h12));
        tbl.push_back(mk(0,0,0,1, 32'h00,   2, 0,0,0,0, 0,0, 1, 32'h13));
        tbl.push_back(mk(0,0,0,1, 32'h00,   1, 0,0,0,1, 0,0, 1, 32'hB0));
        tbl.push_back(mk(0,0,0,1, 32'h00,   0, 1,0,0,1, 0,0, 0, 32'h00));
        tbl.push_back(mk(0,0,1,1, 32'hC0,   1, 0,0,0,1, 0,1, 1, 32'hC0));
        tbl.push_back(mk(0,0,0,1, 32'h00,   0, 1,0,0,1, 0,1, 0, 32'h00));
        tbl.push_back(mk(0,0,0,1, 32'h00,   0, 1,0,0,1, 0,1, 0, 32'h00));
        tbl.push_back(mk(0,1,1,0, 32'hD0,   0, 1,0,0,1, 0,0, 0, 32'h00));
        tbl.push_back(mk(1,1,1,1, 32'hD1,   0, 1,0,0,1, 0,0, 0, 32'h00));

        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].c, tbl[i].w, tbl[i].rd, tbl[i].d);
            check_outputs($sformatf("tbl%0d", i), tbl[i].lvl, tbl[i].emp, tbl[i].full,
                          tbl[i].af, tbl[i].ae, tbl[i].ovf, tbl[i].udf, tbl[i].qchk, tbl[i].q);
        end

        // Wrap-around: one entry in flight, data 0..9 through a 4-deep ring.
        apply(0, 0, 1, 0, 32'h0);
        check_outputs("wrap0", 1, 0, 0, 0, 1, 0, 0, 1, 32'h0);
        for (int k = 1; k < 10; k++) begin
            apply(0, 0, 1, 1, DW'(k));
            check_outputs($sformatf("wrap%0d", k), 1, 0, 0, 0, 1, 0, 0, 1, DW'(k));
        end
        apply(0, 0, 0, 1, 32'h0);
        check_outputs("wrap_end", 0, 1, 0, 0, 1, 0, 0, 0, 32'h0);

        flush_seq(1'b0, "clr");
        flush_seq(1'b1, "rst");

        wbias = 50;
        for (int n = 0; n < 600; n++) begin
            if (n % 50 == 0) wbias = $urandom_range(90, 10);
            r  = ($urandom_range(99) == 0);
            c  = ($urandom_range(39) == 0);
            w  = ($urandom_range(99) < wbias);
            rd = ($urandom_range(99) >= wbias);
            if ($urandom_range(3) == 0) rd = w;
            apply(r, c, w, rd, DW'($urandom));
            check_model($sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
